// File: rtl/sprite_cmd_pkg.sv
// ----------------------------------------------------------------------------
// sprite_cmd_pkg
// Shared definitions for the sprite command-word transmitter:
//   - field widths and bit positions of the 32-bit command word
//   - control and data-type codes
//   - cmd_req_t, the 27-bit queued update request
//   - pack_word(), which assembles a command word from its fields
// Word layout: [31:26] comp_id, [25:21] child, [20:17] control,
//              [16:14] data_type, [13] buffer, [12:0] message
// ----------------------------------------------------------------------------
package sprite_cmd_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned COMP_ID_W = 6;
    localparam int unsigned CHILD_W   = 5;
    localparam int unsigned CTRL_W    = 4;
    localparam int unsigned DT_W      = 3;
    localparam int unsigned MSG_W     = 13;

    localparam int unsigned COMP_ID_LSB = 26;
    localparam int unsigned CHILD_LSB   = 21;
    localparam int unsigned CTRL_LSB    = 17;
    localparam int unsigned DT_LSB      = 14;
    localparam int unsigned BUF_BIT     = 13;
    localparam int unsigned MSG_LSB     = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP    = 4'h0;
    localparam logic [CTRL_W-1:0] CTRL_UPDATE = 4'h1;
    localparam logic [CTRL_W-1:0] CTRL_SWITCH = 4'hF;

    localparam logic [DT_W-1:0] DT_POS     = 3'b000;
    localparam logic [DT_W-1:0] DT_PATTERN = 3'b001;

    typedef struct packed {
        logic [COMP_ID_W-1:0] comp_id;
        logic [CHILD_W-1:0]   child;
        logic [DT_W-1:0]      data_type;
        logic [MSG_W-1:0]     message;
    } cmd_req_t;

    localparam int unsigned REQ_W = $bits(cmd_req_t);

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [COMP_ID_W-1:0] comp_id,
        input logic [CHILD_W-1:0]   child,
        input logic [CTRL_W-1:0]    control,
        input logic [DT_W-1:0]      data_type,
        input logic                 buffer,
        input logic [MSG_W-1:0]     message
    );
        return {comp_id, child, control, data_type, buffer, message};
    endfunction

endpackage

// File: rtl/sprite_cmd_fifo.sv
// ----------------------------------------------------------------------------
// sprite_cmd_fifo
// Single-clock request FIFO of cmd_req_t entries.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset (clears pointers)
//   i_push, i_data   write request; ignored when full unless a pop happens too
//   i_pop            read request; ignored when empty
//   o_data           head entry (valid while o_empty = 0)
//   o_full, o_empty  occupancy flags
//   o_count          occupancy, range 0..DEPTH
// DEPTH must be a power of two and >= 2 so pointers wrap by overflow.
// ----------------------------------------------------------------------------
module sprite_cmd_fifo
    import sprite_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  cmd_req_t                   i_data,
    input  logic                       i_pop,
    output cmd_req_t                   o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    cmd_req_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/sprite_cmd_encoder.sv
// ----------------------------------------------------------------------------
// sprite_cmd_encoder
// Bus-side transmitter of the 32-bit sprite command word. Queues update
// requests, encodes each into an UPDATE word aimed at the back buffer, and
// on frame end issues a SWITCH word and flips the tracked active buffer.
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_req_valid/o_req_ready  request handshake (transfer on valid && ready)
//   i_req_comp_id, i_req_child, i_req_data_type, i_req_message  request fields
//   i_frame_end           one-cycle pulse at end of visible frame
//   o_writedata           registered command word; non-NOP words last one cycle
//   o_active_buffer       buffer currently displayed
//   o_busy                FIFO non-empty or switch pending
//   o_dropped_switches    saturating count of frame_end pulses merged away
// Build option: define SPRITE_CMD_DRAIN_BEFORE_SWITCH_EN to hold the switch
// until the FIFO has drained and to block new requests while it is pending.
// ----------------------------------------------------------------------------
module sprite_cmd_encoder
    import sprite_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [5:0]            i_req_comp_id,
    input  logic [4:0]            i_req_child,
    input  logic [2:0]            i_req_data_type,
    input  logic [12:0]           i_req_message,
    input  logic                  i_frame_end,
    output logic [31:0]           o_writedata,
    output logic                  o_active_buffer,
    output logic                  o_busy,
    output logic [DROP_CNT_W-1:0] o_dropped_switches
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

    logic [WORD_W-1:0]     r_writedata;
    logic                  r_active_buffer;
    logic                  r_switch_pend;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    // Holds req_ready low through reset and releases it on the first clock after.
    logic                  r_ready_en;

    cmd_req_t          w_req;
    cmd_req_t          w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_switch_ok;
    logic              w_drop;
    logic [WORD_W-1:0] w_word_d;

    assign w_req.comp_id   = i_req_comp_id;
    assign w_req.child     = i_req_child;
    assign w_req.data_type = i_req_data_type;
    assign w_req.message   = i_req_message;

`ifdef SPRITE_CMD_DRAIN_BEFORE_SWITCH_EN
    // Queued updates finish in the old back buffer before the flip.
    assign w_switch_ok = r_switch_pend && w_fifo_empty;
    assign w_ready     = r_ready_en && !w_fifo_full && !r_switch_pend;
`else
    assign w_switch_ok = r_switch_pend;
    assign w_ready     = r_ready_en && !w_fifo_full;
`endif

    assign w_push = i_req_valid && w_ready;
    assign w_pop  = !w_switch_ok && !w_fifo_empty;

    // A frame_end that lands while a switch is still waiting gets merged into it.
    assign w_drop = i_frame_end && r_switch_pend && !w_switch_ok;

    sprite_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Both word kinds target the back buffer, i.e. the one not being displayed.
    always_comb begin
        w_word_d = '0;
        if (w_switch_ok) begin
            w_word_d = pack_word('0, '0, CTRL_SWITCH, '0, ~r_active_buffer, '0);
        end else if (w_pop) begin
            w_word_d = pack_word(w_head.comp_id, w_head.child, CTRL_UPDATE,
                                 w_head.data_type, ~r_active_buffer, w_head.message);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_writedata     <= '0;
            r_active_buffer <= 1'b0;
            r_switch_pend   <= 1'b0;
            r_drop_cnt      <= '0;
            r_ready_en      <= 1'b0;
        end else begin
            r_writedata <= w_word_d;
            r_ready_en  <= 1'b1;
            if (w_switch_ok) begin
                r_active_buffer <= ~r_active_buffer;
            end
            // frame_end wins over the clear so a coincident pulse re-arms the switch.
            if (i_frame_end) begin
                r_switch_pend <= 1'b1;
            end else if (w_switch_ok) begin
                r_switch_pend <= 1'b0;
            end
            if (w_drop && !(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + DROP_ONE;
            end
        end
    end

    assign o_req_ready        = w_ready;
    assign o_writedata        = r_writedata;
    assign o_active_buffer    = r_active_buffer;
    assign o_busy             = (w_fifo_count != '0) || r_switch_pend;
    assign o_dropped_switches = r_drop_cnt;

endmodule
